systolic_seq: RTL and testbench

//  Parametrised NxN operand sequencer for the output-stationary systolic array.

---
 rtl/systolic_seq_pkg.sv | 18 +
 rtl/systolic_seq_skew_lane.sv | 41 ++++
 rtl/systolic_seq.sv | 199 +++++++++++++++++++
 tb/tb_systolic_seq.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_seq_pkg.sv
// Shared definitions for the systolic operand sequencer.
//   seq_state_e : sequencer FSM encoding (IDLE=0, LOAD=1, STREAM=2, DRAIN=3, DONE=4)
//   STALL_W     : width of the optional stall counter
//   STALL_MAX   : stall counter saturation value
package systolic_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    localparam int              STALL_W   = 16;
    localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/systolic_seq_skew_lane.sv
// Per-lane skew delay line: DEPTH registered stages of W bits.
// Shifts only while i_en is high; synchronous active-high reset clears all stages.
//   i_clk, i_rst : clock, sync reset
//   i_en         : shift enable
//   i_d          : lane input
//   o_q          : lane output, i_d delayed by DEPTH enabled cycles
module systolic_skew_lane #(
    parameter int W     = 32,
    parameter int DEPTH = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [DEPTH-1:0][W-1:0] stage_q;
    logic [DEPTH-1:0][W-1:0] stage_d;

    always_comb begin
        stage_d = stage_q;
        if (i_en) begin
            stage_d[0] = i_d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign o_q = stage_q[DEPTH-1];

endmodule

// File: rtl/systolic_seq.sv
// Operand sequencer for an NxN output-stationary systolic array.
// Latches a full A/B job on i_start, feeds each lane with a diagonal skew
// (lane j carries element k in cycle s0+k+j), drains, then pulses o_done.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_en           : global advance; low freezes all state and gates pulses
//   i_start        : job request, accepted in IDLE or DONE
//   i_A, i_B       : A(r,k) at [(r*N+k)*W +: W], B(k,c) at [(k*N+c)*W +: W]
//   o_a, o_b       : skewed lanes to array rows / columns
//   o_clr, o_step  : accumulator clear, array step enable
//   o_busy, o_done : handshake
// Optional macro SYSTOLIC_SEQ_PERF_EN adds o_stall_cnt (busy cycles with i_en low).
//
// state  | meaning
// IDLE   | waiting for i_start
// LOAD   | one cycle, clears accumulators, presents element 0 to skew lines
// STREAM | N cycles of operand elements 0..N-1 on lane 0
// DRAIN  | 2N-1 cycles of zeros while skew lines flush
// DONE   | one-cycle completion pulse; may accept the next job
module systolic_seq
    import systolic_seq_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [W*N*N-1:0] i_A,
    input  logic [W*N*N-1:0] i_B,
    output logic [W*N-1:0]   o_a,
    output logic [W*N-1:0]   o_b,
    output logic             o_clr,
    output logic             o_step,
    output logic             o_busy,
`ifdef SYSTOLIC_SEQ_PERF_EN
    output logic [15:0]      o_stall_cnt,
`endif
    output logic             o_done
);

    localparam int CNT_W = $clog2(3*N);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W*N*N-1:0] a_mat_q, a_mat_d;
    logic [W*N*N-1:0] b_mat_q, b_mat_d;
    logic             accept;
    logic             feed_vld;
    int               feed_idx;
    logic [W*N-1:0]   a_feed, b_feed;

    assign accept = i_en && i_start && (state_q == ST_IDLE || state_q == ST_DONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_mat_d = a_mat_q;
        b_mat_d = b_mat_q;
        o_clr   = 1'b0;
        o_step  = 1'b0;
        o_busy  = 1'b0;
        o_done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_mat_d = i_A;
                    b_mat_d = i_B;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                o_clr   = 1'b1;
                o_busy  = 1'b1;
                cnt_d   = CNT_W'(N-1);
                state_d = ST_STREAM;
            end
            ST_STREAM: begin
                o_step = 1'b1;
                o_busy = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(2*N-2);
                    state_d = ST_DRAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DRAIN: begin
                o_step = 1'b1;
                o_busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DONE: begin
                o_done = 1'b1;
                if (accept) begin
                    a_mat_d = i_A;
                    b_mat_d = i_B;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Frozen cycle: hold everything, suppress pulses so they are deferred.
        if (!i_en) begin
            state_d = state_q;
            cnt_d   = cnt_q;
            a_mat_d = a_mat_q;
            b_mat_d = b_mat_q;
            o_clr   = 1'b0;
            o_step  = 1'b0;
            o_done  = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_mat_q <= '0;
            b_mat_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_mat_q <= a_mat_d;
            b_mat_q <= b_mat_d;
        end
    end

    // The skew lines add at least one register, so element k is presented one
    // cycle early: element 0 during LOAD, element N-cnt during STREAM.
    always_comb begin
        feed_vld = 1'b0;
        feed_idx = 0;
        if (state_q == ST_LOAD) begin
            feed_vld = 1'b1;
        end else if (state_q == ST_STREAM && cnt_q != '0) begin
            feed_vld = 1'b1;
            feed_idx = N - int'(cnt_q);
        end
        a_feed = '0;
        b_feed = '0;
        for (int j = 0; j < N; j++) begin
            if (feed_vld) begin
                a_feed[j*W +: W] = a_mat_q[(j*N + feed_idx)*W +: W];
                b_feed[j*W +: W] = b_mat_q[(feed_idx*N + j)*W +: W];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_lane
        systolic_skew_lane #(.W(W), .DEPTH(j+1)) u_skew_a (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_en),
            .i_d   (a_feed[j*W +: W]),
            .o_q   (o_a[j*W +: W])
        );
        systolic_skew_lane #(.W(W), .DEPTH(j+1)) u_skew_b (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_en  (i_en),
            .i_d   (b_feed[j*W +: W]),
            .o_q   (o_b[j*W +: W])
        );
    end

`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (accept) begin
            stall_cnt_d = '0;
        end else if (o_busy && !i_en && stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_seq.sv
// Bench for systolic_seq (N=3, W=8): control timing table, skew values,
// stall / protocol sequences, and a randomized run against a phase-based model.
module tb_systolic_seq;

    localparam int W       = 8;
    localparam int N       = 3;
    localparam int PH_DONE = 3*N + 1;

    logic             i_clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             i_en = 1'b0;
    logic             i_start = 1'b0;
    logic [W*N*N-1:0] i_A = '0;
    logic [W*N*N-1:0] i_B = '0;
    logic [W*N-1:0]   o_a, o_b;
    logic             o_clr, o_step, o_busy, o_done;
`ifdef SYSTOLIC_SEQ_PERF_EN
    logic [15:0]      o_stall_cnt;
`endif

    always #5 i_clk = ~i_clk;

    systolic_seq #(.W(W), .N(N)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_en        (i_en),
        .i_start     (i_start),
        .i_A         (i_A),
        .i_B         (i_B),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_clr       (o_clr),
        .o_step      (o_step),
        .o_busy      (o_busy),
`ifdef SYSTOLIC_SEQ_PERF_EN
        .o_stall_cnt (o_stall_cnt),
`endif
        .o_done      (o_done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: ph = enabled edges since the job was accepted (0 = no job).
    int         ph = 0;
    int         m_stall = 0;
    bit         mdl_on = 1'b0;
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];

    logic [W*N-1:0] last_a, last_b;
    logic           last_done, last_busy, last_clr, last_step;
    logic [31:0]    last_stall;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        logic [W*N-1:0] ea, eb;
        int k;
        logic busy_x;
        ea = '0;
        eb = '0;
        for (int j = 0; j < N; j++) begin
            k = ph - 2 - j;
            if (ph >= 1 && k >= 0 && k < N) begin
                ea[j*W +: W] = ma[j][k];
                eb[j*W +: W] = mb[k][j];
            end
        end
        busy_x = (ph >= 1 && ph <= 3*N);
        chk("m_clr",  32'(o_clr),  32'(ph == 1 && i_en));
        chk("m_step", 32'(o_step), 32'(ph >= 2 && ph <= 3*N && i_en));
        chk("m_busy", 32'(o_busy), 32'(busy_x));
        chk("m_done", 32'(o_done), 32'(ph == PH_DONE && i_en));
        chk("m_a",    32'(o_a),    32'(ea));
        chk("m_b",    32'(o_b),    32'(eb));
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("m_stall", 32'(o_stall_cnt), 32'(m_stall));
`endif
    endtask

    task automatic model_update();
        if (i_rst) begin
            ph      = 0;
            m_stall = 0;
        end else begin
            if (ph >= 1 && ph <= 3*N && !i_en && m_stall < 65535) m_stall++;
            if (i_en) begin
                if ((ph == 0 || ph == PH_DONE) && i_start) begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            ma[r][c] = i_A[(r*N + c)*W +: W];
                            mb[r][c] = i_B[(r*N + c)*W +: W];
                        end
                    end
                    ph      = 1;
                    m_stall = 0;
                end else if (ph >= 1 && ph <= 3*N) begin
                    ph++;
                end else if (ph == PH_DONE) begin
                    ph = 0;
                end
            end
        end
    endtask

    task automatic cyc(input logic rst, input logic en, input logic start);
        @(negedge i_clk);
        i_rst   = rst;
        i_en    = en;
        i_start = start;
        #1;
        last_a    = o_a;
        last_b    = o_b;
        last_done = o_done;
        last_busy = o_busy;
        last_clr  = o_clr;
        last_step = o_step;
`ifdef SYSTOLIC_SEQ_PERF_EN
        last_stall = 32'(o_stall_cnt);
`else
        last_stall = 32'd0;
`endif
        if (mdl_on) model_check();
        @(posedge i_clk);
        model_update();
        if (rst) mdl_on = 1'b1;
        #1;
    endtask

    task automatic rand_mats();
        for (int i = 0; i < N*N; i++) begin
            i_A[i*W +: W] = W'($urandom);
            i_B[i*W +: W] = W'($urandom);
        end
    endtask

    typedef struct {
        logic rst, en, start, chk;
        logic clr, step, busy, done;
    } vec_t;

    vec_t       tbl [14];
    logic [W-1:0] cap_a2 [14];
    logic [W-1:0] cap_b1 [14];
    logic [W-1:0] exp_a2, exp_b1;
    int         done_at;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Control timing table: rows 0-1 reset, row 2 = t0 (start), row 12 = t0+10.
        tbl[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 4; i <= 11; i++) tbl[i] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // A(r,k)=10r+k, B(k,c)=10k+c+100
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                i_A[(r*N + c)*W +: W] = W'(10*r + c);
                i_B[(r*N + c)*W +: W] = W'(10*r + c + 100);
            end
        end

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].rst, tbl[i].en, tbl[i].start);
            cap_a2[i] = last_a[2*W +: W];
            cap_b1[i] = last_b[1*W +: W];
            if (tbl[i].chk) begin
                chk($sformatf("tbl_clr[%0d]", i),  32'(last_clr),  32'(tbl[i].clr));
                chk($sformatf("tbl_step[%0d]", i), 32'(last_step), 32'(tbl[i].step));
                chk($sformatf("tbl_busy[%0d]", i), 32'(last_busy), 32'(tbl[i].busy));
                chk($sformatf("tbl_done[%0d]", i), 32'(last_done), 32'(tbl[i].done));
                if (tbl[i].rst) begin
                    chk("rst_a", 32'(last_a), 32'd0);
                    chk("rst_b", 32'(last_b), 32'd0);
                end
            end
        end

        // Skew: s0 is table row 4; lane 2 of A at s0+2..s0+4, lane 1 of B at s0+1..s0+3.
        for (int i = 2; i < 14; i++) begin
            case (i)
                6: exp_a2 = 8'd20;
                7: exp_a2 = 8'd21;
                8: exp_a2 = 8'd22;
                default: exp_a2 = 8'd0;
            endcase
            case (i)
                5: exp_b1 = 8'd101;
                6: exp_b1 = 8'd111;
                7: exp_b1 = 8'd121;
                default: exp_b1 = 8'd0;
            endcase
            chk($sformatf("skew_a2[%0d]", i), 32'(cap_a2[i]), 32'(exp_a2));
            chk($sformatf("skew_b1[%0d]", i), 32'(cap_b1[i]), 32'(exp_b1));
        end

        // Identity A, B = 1..9: lanes carry the data untouched (model-checked).
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                i_A[(r*N + c)*W +: W] = (r == c) ? W'(1) : W'(0);
                i_B[(r*N + c)*W +: W] = W'(r*N + c + 1);
            end
        end
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 11; i++) cyc(1'b0, 1'b1, 1'b0);

        // Stall: i_en low for 3 cycles mid-STREAM delays o_done by exactly 3.
        rand_mats();
        cyc(1'b0, 1'b1, 1'b1);
        done_at = -1;
        for (int i = 1; i < 40; i++) begin
            cyc(1'b0, !(i >= 3 && i < 6), 1'b0);
            if (last_done) begin
                done_at = i;
                break;
            end
        end
        chk("stall_done_at", 32'(done_at), 32'd13);
`ifdef SYSTOLIC_SEQ_PERF_EN
        chk("stall_cnt", last_stall, 32'd3);
`endif

        // i_start mid-DRAIN ignored; i_start in DONE starts the next job at once.
        rand_mats();
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            if (i == 6) rand_mats();
            cyc(1'b0, 1'b1, (i == 6) || (i == 10));
            chk($sformatf("pr_done[%0d]", i), 32'(last_done), 32'(i == 10));
        end
        cyc(1'b0, 1'b1, 1'b0);
        chk("b2b_clr",  32'(last_clr),  32'd1);
        chk("b2b_busy", 32'(last_busy), 32'd1);

        // Reset during STREAM: back to IDLE, no o_done for the aborted job.
        cyc(1'b0, 1'b1, 1'b0);
        chk("rs_step", 32'(last_step), 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("rs_busy", 32'(last_busy), 32'd0);
        chk("rs_a",    32'(last_a),    32'd0);
        done_at = -1;
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b0);
            if (last_done) done_at = i;
        end
        chk("rs_no_done", 32'(done_at), 32'hFFFF_FFFF);

        // Randomized run against the model.
        for (int i = 0; i < 600; i++) begin
            rand_mats();
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                ($urandom_range(0, 9) < 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
